// File: rtl/mem_bus_responder.sv
// Shared-memory responder for two snooping caches: round-robin arbitration over a word array.
// Latency: grant + LATENCY access cycles + one pulse cycle; losing/late requests are held off while busy.
module mem_bus_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            rw0,
    input  logic [1:0]            rw1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [WORD_WIDTH-1:0] wdata0,
    input  logic [WORD_WIDTH-1:0] wdata1,
    output logic [WORD_WIDTH-1:0] rdata0,
    output logic [WORD_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] raddr0,
    output logic [ADDR_WIDTH-1:0] raddr1,
    output logic                  rd_en0,
    output logic                  rd_en1,
    output logic                  wr_done0,
    output logic                  wr_done1,
    output logic                  busy,
    output logic [1:0]            gnt
);

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WT  = 2'd1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    op_wt_q, op_wt_d;
    logic                    port_q, port_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    busy_q, busy_d;
    logic [1:0]              gnt_q, gnt_d;
    logic [1:0]              rd_en_q, rd_en_d;
    logic [1:0]              wr_done_q, wr_done_d;
    logic [WORD_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [WORD_WIDTH-1:0]   rdata1_q, rdata1_d;
    logic [ADDR_WIDTH-1:0]   raddr0_q, raddr0_d;
    logic [ADDR_WIDTH-1:0]   raddr1_q, raddr1_d;

    logic [WORD_WIDTH-1:0]   mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0]   idx;
    logic [WORD_WIDTH-1:0]   mem_rd;
    logic                    mem_we;
    logic                    req0, req1, pick;

    assign idx    = addr_q[DEPTH_LOG2-1:0];
    assign mem_rd = mem[idx];
    assign req0   = (rw0 == OP_RD) || (rw0 == OP_WT);
    assign req1   = (rw1 == OP_RD) || (rw1 == OP_WT);
    // On a tie the port that did not win last time takes the grant.
    assign pick   = (req0 && req1) ? ~last_grant_q : req1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_wt_d      = op_wt_q;
        port_d       = port_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        busy_d       = busy_q;
        gnt_d        = gnt_q;
        rd_en_d      = 2'b00;
        wr_done_d    = 2'b00;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        raddr0_d     = raddr0_q;
        raddr1_d     = raddr1_q;
        mem_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d      = S_ACCESS;
                    port_d       = pick;
                    last_grant_d = pick;
                    op_wt_d      = pick ? (rw1 == OP_WT) : (rw0 == OP_WT);
                    addr_d       = pick ? addr1 : addr0;
                    wdata_d      = pick ? wdata1 : wdata0;
                    cnt_d        = LAT_M1;
                    busy_d       = 1'b1;
                    gnt_d        = pick ? 2'b10 : 2'b01;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    if (op_wt_q) begin
                        mem_we            = 1'b1;
                        wr_done_d[port_q] = 1'b1;
                    end else begin
                        rd_en_d[port_q] = 1'b1;
                        if (port_q) begin
                            rdata1_d = mem_rd;
                            raddr1_d = addr_q;
                        end else begin
                            rdata0_d = mem_rd;
                            raddr0_d = addr_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            op_wt_q      <= 1'b0;
            port_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            gnt_q        <= 2'b00;
            rd_en_q      <= 2'b00;
            wr_done_q    <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            raddr0_q     <= '0;
            raddr1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_wt_q      <= op_wt_d;
            port_q       <= port_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            gnt_q        <= gnt_d;
            rd_en_q      <= rd_en_d;
            wr_done_q    <= wr_done_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            raddr0_q     <= raddr0_d;
            raddr1_q     <= raddr1_d;
        end
    end

    // Storage survives reset; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[idx] <= wdata_q;
        end
    end

    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign raddr0   = raddr0_q;
    assign raddr1   = raddr1_q;
    assign rd_en0   = rd_en_q[0];
    assign rd_en1   = rd_en_q[1];
    assign wr_done0 = wr_done_q[0];
    assign wr_done1 = wr_done_q[1];
    assign busy     = busy_q;
    assign gnt      = gnt_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: cycle-timed transaction model plus directed scenarios.
module tb_mem_bus_responder;

    localparam int AW  = 16;
    localparam int WW  = 16;
    localparam int DL  = 8;
    localparam int LAT = 3;
    localparam logic [1:0] RD  = 2'd0;
    localparam logic [1:0] WT  = 2'd1;
    localparam logic [1:0] IDL = 2'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    rw0, rw1;
    logic [AW-1:0] addr0, addr1;
    logic [WW-1:0] wdata0, wdata1;
    logic [WW-1:0] rdata0, rdata1;
    logic [AW-1:0] raddr0, raddr1;
    logic          rd_en0, rd_en1, wr_done0, wr_done1, busy;
    logic [1:0]    gnt;

    always #5 clk = ~clk;

    mem_bus_responder #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH_LOG2(DL), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .rdata0(rdata0), .rdata1(rdata1), .raddr0(raddr0), .raddr1(raddr1),
        .rd_en0(rd_en0), .rd_en1(rd_en1), .wr_done0(wr_done0), .wr_done1(wr_done1),
        .busy(busy), .gnt(gnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a grant at the end of cycle g makes the
    // responder busy for cycles g+1..g+LAT+1, with the pulse in the last one.
    bit            m_valid = 0;
    int            cyc = 0;
    bit            m_act = 0;
    int            g_cyc, m_port, m_last, m_idx;
    bit            m_wt, r0, r1;
    logic [AW-1:0] m_addr;
    logic [WW-1:0] m_data;
    logic [WW-1:0] m_mem [int];
    logic          e_busy;
    logic [1:0]    e_gnt, e_rd, e_wd;
    logic [WW-1:0] e_rdata [2];
    logic [AW-1:0] e_raddr [2];

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_valid = 1;
                m_act   = 0;
                m_last  = 1;
                e_busy  = 0;
                e_gnt   = 0;
                e_rd    = 0;
                e_wd    = 0;
                e_rdata = '{default: '0};
                e_raddr = '{default: '0};
            end else if (m_valid) begin
                e_rd = 0;
                e_wd = 0;
                if (m_act && cyc == g_cyc + LAT) begin
                    m_idx = int'(m_addr[DL-1:0]);
                    if (m_wt) begin
                        m_mem[m_idx] = m_data;
                        e_wd[m_port] = 1'b1;
                    end else begin
                        e_rdata[m_port] = m_mem.exists(m_idx) ? m_mem[m_idx] : 'x;
                        e_raddr[m_port] = m_addr;
                        e_rd[m_port]    = 1'b1;
                    end
                end else if (m_act && cyc == g_cyc + LAT + 1) begin
                    m_act = 0;
                end else if (!m_act) begin
                    r0 = (rw0 == RD) || (rw0 == WT);
                    r1 = (rw1 == RD) || (rw1 == WT);
                    if (r0 || r1) begin
                        m_port = (r0 && r1) ? 1 - m_last : (r0 ? 0 : 1);
                        m_last = m_port;
                        m_act  = 1;
                        g_cyc  = cyc;
                        m_wt   = ((m_port == 1) ? rw1 : rw0) == WT;
                        m_addr = (m_port == 1) ? addr1 : addr0;
                        m_data = (m_port == 1) ? wdata1 : wdata0;
                    end
                end
                e_busy = m_act;
                e_gnt  = m_act ? ((m_port == 1) ? 2'b10 : 2'b01) : 2'b00;
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("busy",     32'(busy),     32'(e_busy));
                chk("gnt",      32'(gnt),      32'(e_gnt));
                chk("rd_en0",   32'(rd_en0),   32'(e_rd[0]));
                chk("rd_en1",   32'(rd_en1),   32'(e_rd[1]));
                chk("wr_done0", 32'(wr_done0), 32'(e_wd[0]));
                chk("wr_done1", 32'(wr_done1), 32'(e_wd[1]));
                chk("rdata0",   32'(rdata0),   32'(e_rdata[0]));
                chk("rdata1",   32'(rdata1),   32'(e_rdata[1]));
                chk("raddr0",   32'(raddr0),   32'(e_raddr[0]));
                chk("raddr1",   32'(raddr1),   32'(e_raddr[1]));
            end
        end
    end

    task automatic set_port(input int p, input logic [1:0] rw, input logic [AW-1:0] a,
                            input logic [WW-1:0] d);
        if (p == 0) begin
            rw0 = rw; addr0 = a; wdata0 = d;
        end else begin
            rw1 = rw; addr1 = a; wdata1 = d;
        end
    endtask

    // Counts negedges until port p pulses; drops the request on the pulse.
    task automatic wait_pulse(input int p, output int k);
        bit seen;
        k = 0;
        seen = 0;
        while (!seen && k < 30) begin
            @(negedge clk);
            k++;
            seen = (p == 0) ? (rd_en0 || wr_done0) : (rd_en1 || wr_done1);
        end
        if (!seen) chk("pulse timeout", 32'(k), 32'(LAT + 1));
        if (p == 0) rw0 = IDL; else rw1 = IDL;
    endtask

    task automatic do_op(input int p, input logic [1:0] rw, input logic [AW-1:0] a,
                         input logic [WW-1:0] d, output int k);
        @(negedge clk);
        set_port(p, rw, a, d);
        wait_pulse(p, k);
    endtask

    task automatic tie(input logic [1:0] t0, input logic [AW-1:0] a0, input logic [WW-1:0] d0,
                       input logic [1:0] t1, input logic [AW-1:0] a1, input logic [WW-1:0] d1,
                       output int first, output int k1, output int k2);
        int k;
        bit done0, done1;
        @(negedge clk);
        set_port(0, t0, a0, d0);
        set_port(1, t1, a1, d1);
        k = 0; first = -1; k1 = 0; k2 = 0; done0 = 0; done1 = 0;
        while (!(done0 && done1) && k < 40) begin
            @(negedge clk);
            k++;
            if (!done0 && (rd_en0 || wr_done0)) begin
                done0 = 1; rw0 = IDL;
                if (first < 0) begin first = 0; k1 = k; end else k2 = k;
            end
            if (!done1 && (rd_en1 || wr_done1)) begin
                done1 = 1; rw1 = IDL;
                if (first < 0) begin first = 1; k1 = k; end else k2 = k;
            end
        end
        if (!(done0 && done1)) chk("tie timeout", 32'(k), 32'(2 * LAT + 3));
    endtask

    int k, first, k1, k2;

    initial begin
        reset = 1'b1;
        rw0 = IDL; rw1 = IDL;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset busy",   32'(busy),   32'd0);
        chk("reset gnt",    32'(gnt),    32'd0);
        chk("reset rdata0", 32'(rdata0), 32'd0);
        chk("reset raddr1", 32'(raddr1), 32'd0);

        // Single write: pulse exactly in cycle LAT+1, grant held through it.
        @(negedge clk);
        set_port(0, WT, 16'h0012, 16'hBEEF);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 4) chk("wr gnt", 32'(gnt), 32'h1);
            chk("wr_done0 timing", 32'(wr_done0), 32'(c == 4));
            if (c == 4) rw0 = IDL;
            if (c == 5) chk("wr busy after", 32'(busy), 32'd0);
        end

        do_op(1, RD, 16'h0012, 16'h0000, k);
        chk("rd latency", 32'(k),      32'd4);
        chk("rd rdata1",  32'(rdata1), 32'hBEEF);
        chk("rd raddr1",  32'(raddr1), 32'h0012);
        chk("rd rdata0",  32'(rdata0), 32'h0000);
        chk("rd raddr0",  32'(raddr0), 32'h0000);

        // Ties alternate; the loser is served at the very next idle slot.
        tie(WT, 16'h0105, 16'h1234, WT, 16'h0040, 16'h5555, first, k1, k2);
        chk("tie1 first", 32'(first), 32'd0);
        chk("tie1 k1",    32'(k1),    32'd4);
        chk("tie1 k2",    32'(k2),    32'd9);
        tie(RD, 16'h0005, 16'h0000, RD, 16'h0040, 16'h0000, first, k1, k2);
        chk("tie2 first",   32'(first),  32'd0);
        chk("alias rdata0", 32'(rdata0), 32'h1234);
        chk("alias raddr0", 32'(raddr0), 32'h0005);
        chk("tie2 rdata1",  32'(rdata1), 32'h5555);
        do_op(0, RD, 16'h0012, 16'h0000, k);
        tie(RD, 16'h0105, 16'h0000, RD, 16'h0012, 16'h0000, first, k1, k2);
        chk("tie3 first",  32'(first),  32'd1);
        chk("tie3 rdata1", 32'(rdata1), 32'hBEEF);

        // Reset in the middle of ACCESS aborts the write.
        @(negedge clk);
        set_port(0, WT, 16'h0040, 16'h00AA);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rw0 = IDL;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy",     32'(busy),     32'd0);
        chk("abort gnt",      32'(gnt),      32'd0);
        chk("abort wr_done0", 32'(wr_done0), 32'd0);
        chk("abort rdata0",   32'(rdata0),   32'd0);
        chk("abort rdata1",   32'(rdata1),   32'd0);
        chk("abort raddr1",   32'(raddr1),   32'd0);
        do_op(1, RD, 16'h0040, 16'h0000, k);
        chk("abort old data", 32'(rdata1), 32'h5555);

        // Reserved op never wins a grant.
        @(negedge clk);
        rw0 = 2'd3; rw1 = 2'd3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("reserved busy", 32'(busy), 32'd0);
            chk("reserved gnt",  32'(gnt),  32'd0);
        end
        rw0 = IDL; rw1 = IDL;

        // Inputs changed during ACCESS are ignored.
        @(negedge clk);
        set_port(1, WT, 16'h0077, 16'h1111);
        repeat (2) @(negedge clk);
        addr1 = 16'h0078; wdata1 = 16'h2222;
        wait_pulse(1, k);
        chk("latched wr lat", 32'(k), 32'd2);
        @(negedge clk);
        set_port(0, RD, 16'h0105, 16'h0000);
        repeat (2) @(negedge clk);
        addr0 = 16'h0040;
        wait_pulse(0, k);
        chk("latched rdata0", 32'(rdata0), 32'h1234);
        chk("latched raddr0", 32'(raddr0), 32'h0105);
        do_op(0, RD, 16'h0077, 16'h0000, k);
        chk("latched wdata",  32'(rdata0), 32'h1111);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Shared-memory responder for the two-cache snooping system. It serves the memory-side request interface of both cache controllers: RD/WT/IDLE op, address and write data in; read-data/address return with a read-enable pulse, or a write-done pulse. It arbitrates round-robin between the two ports, holds a word-addressed storage array and returns every response after a fixed, parameterised access latency.

## Interface
- ADDR_WIDTH, 16, address width of both ports
- WORD_WIDTH, 16, data word width
- DEPTH_LOG2, 8, log2 of storage depth in words; index = addr[DEPTH_LOG2-1:0]
- LATENCY, 3, access cycles between grant and response, legal 1..15
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- rw0 / rw1  in  2  port op: 0 RD, 1 WT, 2 IDLE, 3 reserved (treated as IDLE)
- addr0 / addr1  in  ADDR_WIDTH  request address
- wdata0 / wdata1  in  WORD_WIDTH  write data, used when rw = WT
- rdata0 / rdata1  out  WORD_WIDTH  read data returned to port
- raddr0 / raddr1  out  ADDR_WIDTH  echo of the serviced address
- rd_en0 / rd_en1  out  1  one-cycle pulse: read complete, rdata/raddr valid
- wr_done0 / wr_done1  out  1  one-cycle pulse: write committed
- busy  out  1  high in ACCESS and RESP
- gnt  out  2  one-hot granted port (bit0 = port 0), 0 when IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: at each edge, request set = ports with rw ∈ {RD, WT}. Empty set: stay IDLE. One requester: grant it. Both: grant the port not equal to last_grant. On grant: latch op, addr, wdata, port id; set last_grant; load counter with LATENCY-1; go to ACCESS.
- ACCESS: counter decrements each edge; at the edge where counter = 0, go to RESP. At that same edge: WT writes latched wdata into mem[index]; RD loads mem[index] into the granted port's rdata, and the latched addr into its raddr.
- RESP: exactly one cycle; granted port's rd_en (RD) or wr_done (WT) is high; next edge returns to IDLE unconditionally. Requests are not sampled in ACCESS or RESP.
- Requests are level-held: a cache keeps rw/addr/wdata stable from assertion until it sees its pulse, and presents its next op (or IDLE) within the cycle after the pulse. Input changes during ACCESS/RESP are ignored (latched values are used).
- Upper address bits above DEPTH_LOG2 are ignored (aliasing); raddr echoes the full latched address.
- rdata/raddr of a port change only on that port's read completion and hold otherwise; the other port's outputs are untouched.
- Storage is not reset; reads of never-written words return undefined data.

## Timing
- Reset (edge with reset=1): state IDLE, last_grant = port 1 (port 0 wins first tie), counter 0, busy 0, gnt 0, rd_en*/wr_done* 0, rdata* 0, raddr* 0. Storage contents are kept.
- Reset mid-operation: transaction aborted, no pulse issued; write not committed unless the commit edge precedes reset.
- Latency: request visible in cycle 0, granted at the end of cycle 0; ACCESS cycles 1..LATENCY; pulse in cycle LATENCY+1; next request sampled at the end of cycle LATENCY+2 at the earliest (the IDLE cycle). Back-to-back throughput is one transaction per LATENCY+2 cycles.
- busy and gnt are registered: high from cycle 1 through cycle LATENCY+1.
- Write-then-read to the same index returns the new data (commit precedes any later grant).
- Losing port waits; after a grant round-robin guarantees it is granted next while it keeps requesting.

## Test plan
- Reset then single write: port 0 WT addr 0x0012 data 0xBEEF, LATENCY=3 -> wr_done0 high exactly in cycle 4, gnt=01 in cycles 1-4, busy low in cycle 5.
- Read-back: port 1 RD addr 0x0012 after the write above -> rd_en1 pulse after 4 cycles, rdata1=0xBEEF, raddr1=0x0012, rdata0/raddr0 unchanged at 0.
- Tie: both ports request in the same cycle after reset -> port 0 served first, port 1 granted at the next IDLE; repeat the tie -> port 0 then port 1 alternate, never twice in a row.
- Aliasing: DEPTH_LOG2=8, write 0x1234 to 0x0105, read 0x0005 -> rdata=0x1234, raddr=0x0005.
- Reset during ACCESS of WT 0x00AA to 0x0040 (after a prior write of 0x5555) -> no wr_done; subsequent read of 0x0040 returns 0x5555; all outputs 0 the cycle after reset.
- rw=3 on both ports and input changes during ACCESS -> no grant for reserved op; in-flight transaction uses latched addr/data.
